dyn_pattern_gen: RTL and testbench

- Serial stimulus source for the dynamic pattern detector. Emits a 1-bit stream with a valid qualifier.
- Inserts a programmable BITS-wide pattern a programmed number of times, separated by programmable-length filler gaps.
- Flags each inserted instance with a hit marker so a checker can compare it cycle-for-cycle against the detector's out.

---
 rtl/dyn_pattern_gen.sv | 129 ++++++++++++
 tb/tb_dyn_pattern_gen.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dyn_pattern_gen.sv
// Serial stimulus source: emits a BITS-wide pattern `count` times, separated by `gap` filler bits.
// Each inserted instance is flagged with `hit`. Define DPG_LFSR_FILL_EN for LFSR filler bits.
module dyn_pattern_gen #(
    parameter int BITS = 8,
    parameter int GAPW = 8,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] pattern,
    input  logic [GAPW-1:0] gap,
    input  logic [CNTW-1:0] count,
    output logic            valid,
    output logic            out,
    output logic            hit,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] sent
);

    localparam int IDXW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(BITS - 1);

    typedef enum logic [1:0] {IDLE, SEND_PAT, SEND_GAP, DONE} state_t;

    state_t          state;
    logic [IDXW-1:0] bit_idx;
    logic [GAPW-1:0] gap_cnt;
    logic [CNTW-1:0] inst_cnt;
    logic [BITS-1:0] pattern_l;
    logic [GAPW-1:0] gap_l;
    logic [CNTW-1:0] count_l;
    logic            accept;
    logic            sending;
    logic            fill_bit;

    assign accept  = (state == IDLE) && start && (count != '0);
    assign sending = (state == SEND_PAT) || (state == SEND_GAP);

    // Run parameters are frozen at the accepted start; they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pattern_l <= pattern;
            gap_l     <= gap;
            count_l   <= count;
        end
    end

`ifdef DPG_LFSR_FILL_EN
    logic [15:0] lfsr;

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting right; only rst reseeds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (state == SEND_GAP) begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    assign fill_bit = lfsr[0];
`else
    assign fill_bit = ~pattern_l[0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valid    <= 1'b0;
            out      <= 1'b0;
            hit      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sent     <= '0;
            bit_idx  <= '0;
            gap_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            // Outputs lag the state by one cycle, so every output is a flop.
            valid <= sending;
            busy  <= sending;
            out   <= (state == SEND_PAT) ? pattern_l[LAST - bit_idx]
                                         : ((state == SEND_GAP) && fill_bit);
            hit   <= (state == SEND_PAT) && (bit_idx == LAST);
            done  <= (state == DONE);
            sent  <= inst_cnt;

            case (state)
                IDLE: begin
                    if (start) begin
                        inst_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= (count != '0) ? SEND_PAT : DONE;
                    end
                end
                SEND_PAT: begin
                    if (bit_idx == LAST) begin
                        inst_cnt <= inst_cnt + CNTW'(1);
                        bit_idx  <= '0;
                        gap_cnt  <= '0;
                        if (inst_cnt + CNTW'(1) == count_l) begin
                            state <= DONE;
                        end else if (gap_l != '0) begin
                            state <= SEND_GAP;
                        end
                    end else begin
                        bit_idx <= bit_idx + IDXW'(1);
                    end
                end
                SEND_GAP: begin
                    if (gap_cnt == gap_l - GAPW'(1)) begin
                        bit_idx <= '0;
                        state   <= SEND_PAT;
                    end else begin
                        gap_cnt <= gap_cnt + GAPW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dyn_pattern_gen.sv
// Bench for dyn_pattern_gen: directed scenarios plus randomized runs against a stream-level model.
// Define DPG_LFSR_FILL_EN for both files to exercise the LFSR filler build.
module tb_dyn_pattern_gen;

    localparam int BITS = 8;
    localparam int GAPW = 8;
    localparam int CNTW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [BITS-1:0] pattern;
    logic [GAPW-1:0] gap;
    logic [CNTW-1:0] count;
    logic            valid;
    logic            out;
    logic            hit;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] sent;

    int errors = 0;
    int checks = 0;

    bit obs_out[$];
    bit obs_hit[$];
    bit exp_out[$];
    bit exp_hit[$];
    int done_cnt, done_at, first_valid, last_valid, busy_bad;
    logic [15:0] m_lfsr = 16'hACE1;

    dyn_pattern_gen #(.BITS(BITS), .GAPW(GAPW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .gap(gap), .count(count),
        .valid(valid), .out(out), .hit(hit), .busy(busy), .done(done), .sent(sent)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Expected stream: n copies of p (MSB first) separated by g filler bits, no trailing gap.
    task automatic build_expected(input logic [BITS-1:0] p, input int g, input int n);
        exp_out.delete();
        exp_hit.delete();
        for (int k = 0; k < n; k++) begin
            for (int i = BITS - 1; i >= 0; i--) begin
                exp_out.push_back(p[i]);
                exp_hit.push_back(i == 0);
            end
            if (k < n - 1) begin
                for (int j = 0; j < g; j++) begin
`ifdef DPG_LFSR_FILL_EN
                    exp_out.push_back(m_lfsr[0]);
                    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`else
                    exp_out.push_back(~p[0]);
`endif
                    exp_hit.push_back(1'b0);
                end
            end
        end
    endtask

    task automatic launch(input logic [BITS-1:0] p, input int g, input int n);
        @(negedge clk);
        pattern = p;
        gap     = GAPW'(g);
        count   = CNTW'(n);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Records the stream; cycle 0 is the negedge right after the start-sampling edge.
    task automatic capture(input int budget, input int disturb_at);
        obs_out.delete();
        obs_hit.delete();
        done_cnt = 0; done_at = -1; first_valid = -1; last_valid = -1; busy_bad = 0;
        for (int c = 0; c < budget; c++) begin
            if (c > 0) @(negedge clk);
            if (valid === 1'b1) begin
                obs_out.push_back(out);
                obs_hit.push_back(hit);
                if (first_valid < 0) first_valid = c;
                last_valid = c;
            end
            if (busy !== valid) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
            if (c == disturb_at) begin
                pattern = BITS'($urandom);
                gap     = '0;
                count   = CNTW'(1);
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done_at >= 0 && c >= done_at + 3) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; pattern = '0; gap = '0; count = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({valid, out, hit, busy, done, sent} !== '0) begin
            errors++;
            $display("FAIL reset_hold: outputs=%b required all zero", {valid, out, hit, busy, done, sent});
        end
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        repeat (2) @(negedge clk);
        checks++;
        if ({valid, out, hit, busy, done, sent} !== '0) begin
            errors++;
            $display("FAIL reset_idle: outputs=%b required all zero", {valid, out, hit, busy, done, sent});
        end
    endtask

    task automatic test_basic;
        logic [18:0] lit;
        lit = 19'b1010010100010100101;
        build_expected(8'hA5, 3, 2);
        launch(8'hA5, 3, 2);
        capture(200, -1);
        checks++;
        if (obs_out.size() != 19) begin
            errors++; $display("FAIL basic_len: got %0d valid bits, required 19", obs_out.size());
        end
`ifndef DPG_LFSR_FILL_EN
        for (int i = 0; i < 19 && i < obs_out.size(); i++) begin
            checks++;
            if (obs_out[i] !== lit[18-i]) begin
                errors++; $display("FAIL basic_bit%0d: got %0b required %0b", i, obs_out[i], lit[18-i]);
            end
        end
`endif
        for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
            checks++;
            if ({obs_out[i], obs_hit[i]} !== {exp_out[i], exp_hit[i]}) begin
                errors++; $display("FAIL basic_model%0d: out/hit=%b required %b", i, {obs_out[i], obs_hit[i]}, {exp_out[i], exp_hit[i]});
            end
        end
        checks++;
        if (first_valid != 1 || done_at != last_valid + 1 || done_cnt != 1) begin
            errors++; $display("FAIL basic_timing: first=%0d last=%0d done_at=%0d dones=%0d required 1,19,20,1", first_valid, last_valid, done_at, done_cnt);
        end
        checks++;
        if (sent !== CNTW'(2) || busy_bad != 0) begin
            errors++; $display("FAIL basic_sent: sent=%0d busy_bad=%0d required 2,0", sent, busy_bad);
        end
    endtask

    task automatic test_back_to_back;
        build_expected(8'hFF, 0, 3);
        launch(8'hFF, 0, 3);
        capture(200, -1);
        checks++;
        if (obs_out.size() != 24) begin
            errors++; $display("FAIL b2b_len: got %0d valid bits, required 24", obs_out.size());
        end
        for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
            checks++;
            if ({obs_out[i], obs_hit[i]} !== {exp_out[i], exp_hit[i]}) begin
                errors++; $display("FAIL b2b_model%0d: out/hit=%b required %b", i, {obs_out[i], obs_hit[i]}, {exp_out[i], exp_hit[i]});
            end
        end
        checks++;
        if (done_at != last_valid + 1 || done_cnt != 1 || sent !== CNTW'(3)) begin
            errors++; $display("FAIL b2b_done: done_at=%0d last=%0d dones=%0d sent=%0d required last+1,1,3", done_at, last_valid, done_cnt, sent);
        end
    endtask

    task automatic test_zero_count;
        launch(8'h5A, 2, 0);
        capture(50, -1);
        checks++;
        if (first_valid != -1 || done_at != 1 || done_cnt != 1) begin
            errors++; $display("FAIL zero_count: first_valid=%0d done_at=%0d dones=%0d required -1,1,1", first_valid, done_at, done_cnt);
        end
        checks++;
        if (sent !== '0) begin
            errors++; $display("FAIL zero_sent: sent=%0d required 0", sent);
        end
    endtask

    task automatic test_ignore_inputs;
        build_expected(8'h3C, 5, 4);
        launch(8'h3C, 5, 4);
        capture(300, 10);
        checks++;
        if (obs_out.size() != 47 || done_cnt != 1) begin
            errors++; $display("FAIL ignore_len: got %0d bits, %0d dones, required 47,1", obs_out.size(), done_cnt);
        end
        for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
            checks++;
            if ({obs_out[i], obs_hit[i]} !== {exp_out[i], exp_hit[i]}) begin
                errors++; $display("FAIL ignore_model%0d: out/hit=%b required %b", i, {obs_out[i], obs_hit[i]}, {exp_out[i], exp_hit[i]});
            end
        end
        checks++;
        if (sent !== CNTW'(4) || busy_bad != 0) begin
            errors++; $display("FAIL ignore_sent: sent=%0d busy_bad=%0d required 4,0", sent, busy_bad);
        end
    endtask

    task automatic test_async_reset;
        logic [7:0] lit;
        lit = 8'h81;
        launch(8'hC2, 6, 2);
        repeat (10) @(negedge clk);
        checks++;
        if (valid !== 1'b1 || hit !== 1'b0) begin
            errors++; $display("FAIL areset_pre: valid/hit=%b required 10", {valid, hit});
        end
`ifndef DPG_LFSR_FILL_EN
        checks++;
        if (out !== 1'b1) begin
            errors++; $display("FAIL areset_pre_out: out=%b required 1", out);
        end
`endif
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({valid, busy, out, hit, done} !== 5'b0) begin
            errors++; $display("FAIL areset_fall: valid/busy/out/hit/done=%b required 00000", {valid, busy, out, hit, done});
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({valid, busy, done} !== 3'b0) begin
            errors++; $display("FAIL areset_hold: valid/busy/done=%b required 000", {valid, busy, done});
        end
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        launch(8'h81, 1, 1);
        capture(100, -1);
        checks++;
        if (obs_out.size() != 8 || done_cnt != 1 || done_at != last_valid + 1) begin
            errors++; $display("FAIL areset_run: bits=%0d dones=%0d done_at=%0d required 8,1,%0d", obs_out.size(), done_cnt, done_at, last_valid + 1);
        end
        for (int i = 0; i < 8 && i < obs_out.size(); i++) begin
            checks++;
            if ({obs_out[i], obs_hit[i]} !== {lit[7-i], 1'(i == 7)}) begin
                errors++; $display("FAIL areset_bit%0d: out/hit=%b required %b", i, {obs_out[i], obs_hit[i]}, {lit[7-i], 1'(i == 7)});
            end
        end
    endtask

`ifdef DPG_LFSR_FILL_EN
    task automatic test_lfsr_runs;
        logic [15:0] first_gap;
        logic [15:0] second_gap;
        first_gap = '0;
        second_gap = '0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_lfsr = 16'hACE1;
        for (int r = 0; r < 2; r++) begin
            build_expected(8'h00, 16, 2);
            launch(8'h00, 16, 2);
            capture(200, -1);
            checks++;
            if (obs_out.size() != 32 || done_cnt != 1) begin
                errors++; $display("FAIL lfsr_len%0d: bits=%0d dones=%0d required 32,1", r, obs_out.size(), done_cnt);
            end
            for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
                checks++;
                if ({obs_out[i], obs_hit[i]} !== {exp_out[i], exp_hit[i]}) begin
                    errors++; $display("FAIL lfsr_model%0d_%0d: out/hit=%b required %b", r, i, {obs_out[i], obs_hit[i]}, {exp_out[i], exp_hit[i]});
                end
            end
            for (int i = 0; i < 16 && i + 8 < obs_out.size(); i++) begin
                if (r == 0) first_gap[i] = obs_out[i+8];
                else second_gap[i] = obs_out[i+8];
            end
        end
        checks++;
        if (first_gap === second_gap) begin
            errors++; $display("FAIL lfsr_continue: second gap %h repeats first %h, required a different segment", second_gap, first_gap);
        end
    endtask
`endif

    task automatic test_random;
        logic [BITS-1:0] p;
        int g, n;
        for (int r = 0; r < 10; r++) begin
            p = BITS'($urandom);
            g = int'($urandom_range(0, 4));
            n = int'($urandom_range(0, 4));
            build_expected(p, g, n);
            launch(p, g, n);
            capture(200, -1);
            checks++;
            if (obs_out.size() != exp_out.size() || done_cnt != 1) begin
                errors++; $display("FAIL rand%0d_len: bits=%0d dones=%0d required %0d,1 (p=%h g=%0d n=%0d)", r, obs_out.size(), done_cnt, exp_out.size(), p, g, n);
            end
            for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
                checks++;
                if ({obs_out[i], obs_hit[i]} !== {exp_out[i], exp_hit[i]}) begin
                    errors++; $display("FAIL rand%0d_bit%0d: out/hit=%b required %b", r, i, {obs_out[i], obs_hit[i]}, {exp_out[i], exp_hit[i]});
                end
            end
            checks++;
            if (done_at != ((n == 0) ? 1 : last_valid + 1) || sent !== CNTW'(n) || busy_bad != 0) begin
                errors++; $display("FAIL rand%0d_done: done_at=%0d sent=%0d busy_bad=%0d required %0d,%0d,0", r, done_at, sent, busy_bad, (n == 0) ? 1 : last_valid + 1, n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_count();
        test_ignore_inputs();
        test_async_reset();
`ifdef DPG_LFSR_FILL_EN
        test_lfsr_runs();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
